// File: rtl/input_reg_sequencer_if.sv
// Latch-side and consumer-side signals of the input register sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface input_reg_sequencer_if #(
   parameter int unsigned WIDTH = 48
);
   localparam int unsigned MW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pattern;
   logic [MW-1:0]    multiplicity;
   logic             pattern_valid;
   logic             pattern_ack;
   logic             busy;
   logic [15:0]      event_count;
   logic [15:0]      drop_count;

   modport master (
      input  q, mask, pattern_ack,
      output clr, pattern, multiplicity, pattern_valid, busy, event_count, drop_count
   );

   modport slave (
      output q, mask, pattern_ack,
      input  clr, pattern, multiplicity, pattern_valid, busy, event_count, drop_count
   );
endinterface

// File: rtl/input_reg_sequencer.sv
// Edge-latch sequencer: coincidence window, pattern freeze with valid/ack,
// latch clear and dead time before re-arming.
module input_reg_sequencer #(
   parameter int unsigned WIDTH       = 48,
   parameter int unsigned WINDOW      = 4,
   parameter int unsigned HOLD        = 2,
   parameter int unsigned DEADTIME    = 8,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input logic                   clk,
   input logic                   rst,
   input_reg_sequencer_if.master bus
);
   localparam int unsigned MW     = $clog2(WIDTH + 1);
   localparam int unsigned CMAX_A = (WINDOW > HOLD) ? WINDOW : HOLD;
   localparam int unsigned CMAX_B = (DEADTIME > ACK_TIMEOUT) ? DEADTIME : ACK_TIMEOUT;
   localparam int unsigned CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
   localparam int unsigned CW     = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WIN,
      S_CAPTURE,
      S_WAIT,
      S_CLEAR,
      S_DEAD
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] q_s1;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] act;

   assign act = q_s & ~bus.mask;

   function automatic logic [MW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [MW-1:0] n;
      n = '0;
      for (int i = 0; i < int'(WIDTH); i++) n = n + MW'(v[i]);
      return n;
   endfunction

   // One shared down-counter serves the window, ack timeout, hold and dead phases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         q_s1              <= '0;
         q_s               <= '0;
         bus.clr           <= '1;
         bus.pattern       <= '0;
         bus.multiplicity  <= '0;
         bus.pattern_valid <= 1'b0;
         bus.busy          <= 1'b0;
         bus.event_count   <= '0;
         bus.drop_count    <= '0;
      end else begin
         q_s1    <= bus.q;
         q_s     <= q_s1;
         bus.clr <= bus.mask;

         case (state)
            S_IDLE: begin
               if (|act) begin
                  state    <= S_WIN;
                  cnt      <= CW'(WINDOW - 1);
                  bus.busy <= 1'b1;
               end
            end

            S_WIN: begin
               if (cnt == '0) state <= S_CAPTURE;
               else           cnt   <= cnt - CW'(1);
            end

            S_CAPTURE: begin
               bus.pattern       <= act;
               bus.multiplicity  <= popcount(act);
               bus.pattern_valid <= 1'b1;
               cnt               <= CW'(ACK_TIMEOUT - 1);
               state             <= S_WAIT;
            end

            // Ack is tested first so it wins over a simultaneous timeout.
            S_WAIT: begin
               if (bus.pattern_valid && bus.pattern_ack) begin
                  bus.pattern_valid <= 1'b0;
                  if (bus.event_count != 16'hFFFF) bus.event_count <= bus.event_count + 16'd1;
                  bus.clr <= '1;
                  cnt     <= CW'(HOLD - 1);
                  state   <= S_CLEAR;
               end else if (cnt == '0) begin
                  bus.pattern_valid <= 1'b0;
                  if (bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 16'd1;
                  bus.clr <= '1;
                  cnt     <= CW'(HOLD - 1);
                  state   <= S_CLEAR;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            S_CLEAR: begin
               if (cnt == '0) begin
                  cnt   <= CW'(DEADTIME - 1);
                  state <= S_DEAD;
               end else begin
                  bus.clr <= '1;
                  cnt     <= cnt - CW'(1);
               end
            end

            S_DEAD: begin
               if (cnt == '0) begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_input_reg_sequencer.sv
// Scoreboard bench for input_reg_sequencer with a behavioural edge-latch model.
module tb_input_reg_sequencer;
   localparam int unsigned WIDTH       = 48;
   localparam int unsigned WINDOW      = 4;
   localparam int unsigned HOLD        = 2;
   localparam int unsigned DEADTIME    = 8;
   localparam int unsigned ACK_TIMEOUT = 64;
   localparam logic [WIDTH-1:0] ONES   = '1;

   typedef struct {
      logic [WIDTH-1:0] pattern;
      int               mult;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   input_reg_sequencer_if #(.WIDTH(WIDTH)) bus ();

   input_reg_sequencer #(
      .WIDTH(WIDTH), .WINDOW(WINDOW), .HOLD(HOLD),
      .DEADTIME(DEADTIME), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_fail   = 0;
   int               exp_events = 0;
   int               exp_drops  = 0;
   exp_t             sb[$];
   logic [WIDTH-1:0] latch = '0;
   logic [WIDTH-1:0] noise = '0;
   logic [WIDTH-1:0] last_pattern = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Latch model: bits held in reset by clr are cleared just after each edge.
   task automatic tick();
      @(posedge clk);
      #1;
      latch = latch & ~bus.clr;
      bus.q = latch | noise;
   endtask

   task automatic hit(input int ch);
      if (!bus.clr[ch]) latch[ch] = 1'b1;
      bus.q = latch | noise;
   endtask

   task automatic expect_event(input logic [WIDTH-1:0] pat);
      exp_t e;
      e.pattern = pat;
      e.mult    = $countones(pat);
      sb.push_back(e);
   endtask

   task automatic await_valid(output int n);
      exp_t e;
      n = 0;
      while (!bus.pattern_valid && n < 200) begin
         tick();
         n++;
      end
      if (!bus.pattern_valid) chk("valid_timeout", 64'(bus.pattern_valid), 64'd1);
      else if (sb.size() == 0) chk("sb_depth", 64'(sb.size()), 64'd1);
      else begin
         e = sb.pop_front();
         chk("pattern", 64'(bus.pattern), 64'(e.pattern));
         chk("multiplicity", 64'(bus.multiplicity), 64'(e.mult));
         last_pattern = e.pattern;
      end
   endtask

   task automatic ack_now();
      bus.pattern_ack = 1'b1;
      tick();
      bus.pattern_ack = 1'b0;
      exp_events++;
      chk("valid_after_ack", 64'(bus.pattern_valid), 64'd0);
      chk("clr_after_ack", 64'(bus.clr), 64'(ONES));
      chk("event_count", 64'(bus.event_count), 64'(exp_events));
      chk("drop_count", 64'(bus.drop_count), 64'(exp_drops));
   endtask

   // Measures the clear pulse and the dead time; optionally hits a channel in DEAD.
   task automatic finish_event(input int dead_hit);
      int n;
      int m;
      n = 0;
      while (bus.clr === ONES && n < 20) begin
         n++;
         tick();
      end
      chk("clr_hold_cycles", 64'(n), 64'(HOLD));
      if (dead_hit >= 0) hit(dead_hit);
      m = 0;
      while (bus.busy && m < 40) begin
         m++;
         tick();
      end
      chk("dead_cycles", 64'(m), 64'(DEADTIME));
      chk("pattern_hold", 64'(bus.pattern), 64'(last_pattern));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      rst             = 1'b1;
      bus.q           = '0;
      bus.mask        = '0;
      bus.pattern_ack = 1'b0;
      repeat (3) tick();
      chk("rst_clr", 64'(bus.clr), 64'(ONES));
      chk("rst_valid", 64'(bus.pattern_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_pattern", 64'(bus.pattern), 64'd0);
      chk("rst_mult", 64'(bus.multiplicity), 64'd0);
      chk("rst_events", 64'(bus.event_count), 64'd0);
      chk("rst_drops", 64'(bus.drop_count), 64'd0);
      rst = 1'b0;
      tick();
      chk("idle_clr", 64'(bus.clr), 64'd0);

      // Stray ack while idle must be ignored.
      bus.pattern_ack = 1'b1;
      tick();
      bus.pattern_ack = 1'b0;
      tick();
      chk("idle_ack_ignored", 64'(bus.event_count), 64'd0);

      // Single hit on channel 5, ack one cycle after valid.
      expect_event(48'h0000_0000_0020);
      hit(5);
      n = 0;
      while (!bus.busy && n < 10) begin
         tick();
         n++;
      end
      chk("sync_latency_2to3", 64'(n >= 2 && n <= 3), 64'd1);
      await_valid(n);
      chk("valid_latency", 64'(n), 64'(WINDOW + 1));
      tick();
      ack_now();
      finish_event(-1);

      // Channels 0 and 47 three cycles apart coalesce into one event.
      expect_event(48'h8000_0000_0001);
      hit(0);
      repeat (3) tick();
      hit(47);
      await_valid(n);
      ack_now();
      finish_event(-1);

      // A hit arriving in DEAD is kept and starts the next event.
      expect_event(48'h0000_0000_0001);
      hit(0);
      await_valid(n);
      ack_now();
      expect_event(48'h8000_0000_0000);
      finish_event(47);
      await_valid(n);
      ack_now();
      finish_event(-1);

      // Masked channel 10 toggling must neither start an event nor appear.
      bus.mask = 48'h0000_0000_0400;
      tick();
      tick();
      bad = 0;
      repeat (6) begin
         noise[10] = ~noise[10];
         bus.q = latch | noise;
         tick();
         if (bus.clr[10] !== 1'b1) bad++;
      end
      chk("mask_clr10_idle", 64'(bad), 64'd0);
      chk("mask_no_event", 64'(bus.busy), 64'd0);
      noise[10] = 1'b1;
      expect_event(48'h0000_0000_0008);
      hit(3);
      await_valid(n);
      ack_now();
      finish_event(-1);
      noise = '0;
      bus.q = latch;
      repeat (3) tick();
      bus.mask = '0;
      tick();

      // Masking channel 21 during WIN removes it from the pattern.
      expect_event(48'h0000_0010_0000);
      hit(20);
      hit(21);
      n = 0;
      while (!bus.busy && n < 10) begin
         tick();
         n++;
      end
      bus.mask[21] = 1'b1;
      await_valid(n);
      ack_now();
      finish_event(-1);
      bus.mask = '0;
      tick();

      // No ack: event dropped after the timeout, clear still runs.
      expect_event(48'h0000_0000_0080);
      hit(7);
      await_valid(n);
      n = 0;
      while (bus.pattern_valid && n < 100) begin
         tick();
         n++;
      end
      exp_drops++;
      chk("timeout_cycles", 64'(n), 64'(ACK_TIMEOUT));
      chk("drop_count_timeout", 64'(bus.drop_count), 64'(exp_drops));
      chk("events_after_drop", 64'(bus.event_count), 64'(exp_events));
      chk("timeout_clr", 64'(bus.clr), 64'(ONES));
      finish_event(-1);

      // Ack in the same cycle as timeout expiry: ack wins.
      expect_event(48'h0000_0000_0100);
      hit(8);
      await_valid(n);
      repeat (ACK_TIMEOUT - 1) tick();
      chk("valid_at_expiry", 64'(bus.pattern_valid), 64'd1);
      ack_now();
      finish_event(-1);

      // Reset during WAIT discards the pattern immediately.
      expect_event(48'h0000_0000_0200);
      hit(9);
      await_valid(n);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_wait_valid", 64'(bus.pattern_valid), 64'd0);
      chk("rst_wait_busy", 64'(bus.busy), 64'd0);
      chk("rst_wait_clr", 64'(bus.clr), 64'(ONES));
      chk("rst_wait_events", 64'(bus.event_count), 64'd0);
      exp_events = 0;
      exp_drops  = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      expect_event(48'h0000_0000_0800);
      hit(11);
      await_valid(n);
      chk("post_rst_latency", 64'(n >= WINDOW + 1 && n <= WINDOW + 4), 64'd1);
      ack_now();
      finish_event(-1);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/input_reg_sequencer.md
# input_reg_sequencer

Sequencer for the 48-channel edge-latch register at the trigger front end. Watches the latched hit pattern, opens a fixed coincidence window on the first hit, and freezes the pattern for the downstream trigger logic with a valid/ack handshake. It then drives the latch's per-channel reset vector to clear all channels, and enforces a dead time before re-arming. It is the only driver of the latch reset vector.

## Interface
- WIDTH, 48, number of channels; equals the latch width.
- WINDOW, 4, coincidence window length in clk cycles; must be ≥1.
- HOLD, 2, number of cycles the clear vector is asserted; must be ≥1.
- DEADTIME, 8, number of re-arm cycles after the clear; must be ≥3 to cover the synchroniser flush.
- ACK_TIMEOUT, 64, number of cycles to wait for pattern_ack before dropping the event.
- clk  in  1  system clock; all state changes on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- q  in  WIDTH  latch outputs; asynchronous to clk.
- mask  in  WIDTH  1 = channel disabled; quasi-static.
- clr  out  WIDTH  per-channel latch reset; drives the latch's rst vector.
- pattern  out  WIDTH  frozen hit pattern.
- multiplicity  out  $clog2(WIDTH+1)  popcount of pattern.
- pattern_valid  out  1  pattern/multiplicity valid.
- pattern_ack  in  1  consumer accepts the pattern.
- busy  out  1  high whenever state ≠ IDLE.
- event_count  out  16  number of accepted events; saturates at 0xFFFF.
- drop_count  out  16  number of events dropped by timeout; saturates at 0xFFFF.

## Operation
- Synchroniser: q passes through a 2-flop synchroniser to give q_s. The working vector is act = q_s & ~mask.
- IDLE: clr = mask, so masked channels are held in clear. When |act = 1, the block moves to WIN and loads the window counter with WINDOW-1.
- WIN: the counter decrements each cycle. When it reaches 0, the block moves to CAPTURE. Hits arriving during WIN accumulate in the latch.
- CAPTURE (1 cycle): pattern <= act, multiplicity <= popcount(act), pattern_valid <= 1. The timeout counter is loaded with ACK_TIMEOUT-1. The block then moves to WAIT.
- WAIT: on pattern_ack = 1, pattern_valid <= 0 and event_count increments; the block moves to CLEAR. If the timeout counter reaches 0 with no ack, pattern_valid <= 0 and drop_count increments; the block moves to CLEAR. If ack arrives in the same cycle as the timeout expiry, the ack wins.
- CLEAR: clr = all ones for HOLD cycles, then the block moves to DEAD.
- DEAD: clr = mask for DEADTIME cycles, then the block returns to IDLE. Hits that arrive during DEAD stay in the latch and start a new window on return to IDLE; they are never lost.
- pattern and multiplicity keep their value until the next CAPTURE.
- pattern_ack is ignored when pattern_valid = 0.
- Mask changes take effect on the next cycle. Masking a channel during WIN removes it from the captured pattern.

## Timing
- Reset values: state = IDLE, clr = all ones (latches are cleared while rst is high), pattern = 0, multiplicity = 0, pattern_valid = 0, busy = 0, event_count = 0, drop_count = 0, synchroniser = 0, all internal counters = 0.
- Reset mid-operation: the block returns to IDLE immediately. Any pending pattern is discarded, with no count update.
- Latency from a latch rising edge to exit from IDLE: 2–3 cycles (synchroniser).
- Latency from IDLE exit to pattern_valid high: WINDOW + 1 cycles.
- After the ack cycle, clr is high for exactly HOLD cycles starting the next cycle.
- Minimum event period with ack returned in the capture cycle: 3 + WINDOW + 1 + 1 + HOLD + DEADTIME cycles. With defaults this is 19 cycles.
- clr is a registered output, glitch-free, and changes only on posedge clk.

## Test plan
- Hit on channel 5 only, ack one cycle after valid → pattern = 0x000000000020 and multiplicity = 1. pattern_valid rises 5 cycles after IDLE exit. clr is all ones for 2 cycles. event_count = 1. busy drops DEADTIME cycles after the clear ends.
- Hits on channels 0 and 47 spaced 3 cycles apart (inside WINDOW=4) → a single event with multiplicity = 2. Spacing them 6 cycles apart → two events, and the second channel is captured after DEAD.
- Masked channel 10 toggles while channel 3 hits → pattern bit 10 = 0 and clr[10] = 1 throughout IDLE.
- Ack never arrives → pattern_valid drops after 64 cycles, drop_count = 1, the clear sequence still runs, and event_count stays 0.
- Ack in the same cycle as timeout expiry → event_count increments and drop_count is unchanged.
- rst asserted during WAIT → pattern_valid = 0, busy = 0 and clr = all ones immediately. After rst is released, a new hit produces a normal event.
